// File: rtl/gbuff_loader.sv
// Global-buffer loader: streams A then B words into two buffers, kicks the TPU, waits for done.
// Optional GBUFF_LOADER_PERF_EN adds a saturating stall counter output.
module gbuff_loader #(
    parameter int WORD_W = 32,
    parameter int IDX_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_valid,
    input  logic [3:0]        m,
    input  logic [3:0]        k,
    input  logic [3:0]        n,
    input  logic              in_valid,
    input  logic [WORD_W-1:0] in_data,
    output logic              in_ready,
    output logic              wr_en_a,
    output logic              wr_en_b,
    output logic [IDX_W-1:0]  index_a,
    output logic [IDX_W-1:0]  index_b,
    output logic [WORD_W-1:0] data_out_a,
    output logic [WORD_W-1:0] data_out_b,
    output logic              tpu_start,
    input  logic              tpu_done,
    output logic              busy,
    output logic              err,
    output logic              done
`ifdef GBUFF_LOADER_PERF_EN
    ,
    output logic [15:0]       stall_cnt
`endif
);

    typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, START, WAIT} state_t;

    state_t            state;
    state_t            state_nx;
    logic [3:0]        m_q;
    logic [3:0]        k_q;
    logic [3:0]        n_q;
    logic [2:0]        m_blk;
    logic [2:0]        n_blk;
    logic [6:0]        na;
    logic [6:0]        nb;
    logic [6:0]        cnt;
    logic              cfg_ok;
    logic              accept;
    logic              xfer;
    logic              xfer_a;
    logic              xfer_b;
    logic [IDX_W-1:0]  idx_a_q;
    logic [IDX_W-1:0]  idx_b_q;
    logic [WORD_W-1:0] dat_a_q;
    logic [WORD_W-1:0] dat_b_q;

    // Word counts: k rows of ceil(dim/4) packed words each.
    assign m_blk  = 3'((5'(m_q) + 5'd3) >> 2);
    assign n_blk  = 3'((5'(n_q) + 5'd3) >> 2);
    assign na     = 7'(k_q) * 7'(m_blk);
    assign nb     = 7'(k_q) * 7'(n_blk);

    assign cfg_ok = cfg_valid && (m != 4'd0) && (k != 4'd0) && (n != 4'd0);
    assign accept = (state == IDLE) && cfg_ok;

    assign in_ready  = (state == LOAD_A) || (state == LOAD_B);
    assign xfer      = in_valid && in_ready;
    assign xfer_a    = xfer && (state == LOAD_A);
    assign xfer_b    = xfer && (state == LOAD_B);
    assign tpu_start = (state == START);
    assign busy      = (state != IDLE);

    // Write ports are combinational on a transfer and otherwise replay the last write.
    assign wr_en_a    = xfer_a;
    assign wr_en_b    = xfer_b;
    assign index_a    = xfer_a ? IDX_W'(cnt) : idx_a_q;
    assign index_b    = xfer_b ? IDX_W'(cnt) : idx_b_q;
    assign data_out_a = xfer_a ? in_data : dat_a_q;
    assign data_out_b = xfer_b ? in_data : dat_b_q;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = LOAD_A;
            LOAD_A:  if (xfer && (cnt == na - 7'd1)) state_nx = LOAD_B;
            LOAD_B:  if (xfer && (cnt == nb - 7'd1)) state_nx = START;
            START:   state_nx = WAIT;
            WAIT:    if (tpu_done) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Word counter: restarts at every state change, advances per transfer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                    cnt <= '0;
        else if (state != state_nx) cnt <= '0;
        else if (xfer)              cnt <= cnt + 7'd1;
    end

    // Latched dimensions, taken only from a legal configuration in IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_q <= '0;
            k_q <= '0;
            n_q <= '0;
        end else if (accept) begin
            m_q <= m;
            k_q <= k;
            n_q <= n;
        end
    end

    // Hold the last write of each buffer so the idle port stays stable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_a_q <= '0;
            idx_b_q <= '0;
            dat_a_q <= '0;
            dat_b_q <= '0;
        end else begin
            if (xfer_a) begin
                idx_a_q <= IDX_W'(cnt);
                dat_a_q <= in_data;
            end
            if (xfer_b) begin
                idx_b_q <= IDX_W'(cnt);
                dat_b_q <= in_data;
            end
        end
    end

    // Sticky error updated by each configuration seen in IDLE; done follows tpu_done in WAIT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err  <= 1'b0;
            done <= 1'b0;
        end else begin
            if ((state == IDLE) && cfg_valid) err <= !cfg_ok;
            done <= (state == WAIT) && tpu_done;
        end
    end

`ifdef GBUFF_LOADER_PERF_EN
    // Count load cycles starved of input, saturating.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_cnt <= '0;
        else if (accept)
            stall_cnt <= '0;
        else if (in_ready && !in_valid && (stall_cnt != 16'hFFFF))
            stall_cnt <= stall_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_gbuff_loader.sv
// Directed bench for gbuff_loader: load sequencing, stalls, errors, reset, ignored controls.
// Stall counter checks are active when GBUFF_LOADER_PERF_EN is defined.
module tb_gbuff_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_valid;
    logic [3:0]  m;
    logic [3:0]  k;
    logic [3:0]  n;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic        wr_en_a;
    logic        wr_en_b;
    logic [15:0] index_a;
    logic [15:0] index_b;
    logic [31:0] data_out_a;
    logic [31:0] data_out_b;
    logic        tpu_start;
    logic        tpu_done;
    logic        busy;
    logic        err;
    logic        done;
`ifdef GBUFF_LOADER_PERF_EN
    logic [15:0] stall_cnt;
`endif

    int errors = 0;
    int checks = 0;

    gbuff_loader #(.WORD_W(32), .IDX_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_valid  (cfg_valid),
        .m          (m),
        .k          (k),
        .n          (n),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .wr_en_a    (wr_en_a),
        .wr_en_b    (wr_en_b),
        .index_a    (index_a),
        .index_b    (index_b),
        .data_out_a (data_out_a),
        .data_out_b (data_out_b),
        .tpu_start  (tpu_start),
        .tpu_done   (tpu_done),
        .busy       (busy),
        .err        (err),
        .done       (done)
`ifdef GBUFF_LOADER_PERF_EN
        ,
        .stall_cnt  (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ready"}, 32'(in_ready), 0);
        chk({tag, "_wra"}, 32'(wr_en_a), 0);
        chk({tag, "_wrb"}, 32'(wr_en_b), 0);
        chk({tag, "_idxa"}, 32'(index_a), 0);
        chk({tag, "_idxb"}, 32'(index_b), 0);
        chk({tag, "_data"}, data_out_a, 0);
        chk({tag, "_datb"}, data_out_b, 0);
        chk({tag, "_start"}, 32'(tpu_start), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_err"}, 32'(err), 0);
        chk({tag, "_done"}, 32'(done), 0);
    endtask

    int          ai;
    int          bi;
    logic [31:0] last_a;
    logic [31:0] last_b;
    logic [15:0] hold_a;
    logic [15:0] hold_b;

    initial begin
        rst = 1'b1;
        cfg_valid = 1'b0;
        m = 4'd0;
        k = 4'd0;
        n = 4'd0;
        in_valid = 1'b0;
        in_data = 32'd0;
        tpu_done = 1'b0;
        @(negedge clk);
        #1;
        chk_all_zero("rst0");
        cyc();
        rst = 1'b0;

        // Scenario 1: 4x4x4, continuous stream
        cfg_valid = 1'b1;
        m = 4'd4;
        k = 4'd4;
        n = 4'd4;
        in_valid = 1'b1;
        in_data = 32'hDEAD0000;
        #1;
        chk("s1_cfg_ready", 32'(in_ready), 0);
        chk("s1_cfg_wra", 32'(wr_en_a), 0);
        cyc();
        cfg_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_data = 32'hA0000000 | 32'(i);
            #1;
            chk("s1_a_wr", 32'(wr_en_a), 1);
            chk("s1_a_idx", 32'(index_a), 32'(i));
            chk("s1_a_dat", data_out_a, 32'hA0000000 | 32'(i));
            chk("s1_a_wrb", 32'(wr_en_b), 0);
            chk("s1_a_busy", 32'(busy), 1);
            cyc();
        end
        for (int i = 0; i < 4; i++) begin
            in_data = 32'hB0000000 | 32'(i);
            #1;
            chk("s1_b_wr", 32'(wr_en_b), 1);
            chk("s1_b_idx", 32'(index_b), 32'(i));
            chk("s1_b_dat", data_out_b, 32'hB0000000 | 32'(i));
            chk("s1_b_wra", 32'(wr_en_a), 0);
            chk("s1_b_holdidx", 32'(index_a), 3);
            chk("s1_b_holddat", data_out_a, 32'hA0000003);
            cyc();
        end
        #1;
        chk("s1_start", 32'(tpu_start), 1);
        chk("s1_start_ready", 32'(in_ready), 0);
        chk("s1_start_wrb", 32'(wr_en_b), 0);
        chk("s1_start_idxb", 32'(index_b), 3);
`ifdef GBUFF_LOADER_PERF_EN
        chk("s1_stall", 32'(stall_cnt), 0);
`endif
        cyc();
        in_valid = 1'b0;
        #1;
        chk("s1_wait_start", 32'(tpu_start), 0);
        chk("s1_wait_busy", 32'(busy), 1);
        tpu_done = 1'b1;
        cyc();
        tpu_done = 1'b0;
        #1;
        chk("s1_done", 32'(done), 1);
        chk("s1_done_busy", 32'(busy), 0);
        cyc();
        #1;
        chk("s1_done_once", 32'(done), 0);

        // Scenario 2 + 5: m=5 k=3 n=1 (NA=6, NB=3), toggling valid, stray tpu_done
        cfg_valid = 1'b1;
        m = 4'd5;
        k = 4'd3;
        n = 4'd1;
        cyc();
        cfg_valid = 1'b0;
        ai = 0;
        bi = 0;
        hold_a = 16'd3;
        hold_b = 16'd3;
        last_a = 32'hA0000003;
        last_b = 32'hB0000003;
        for (int j = 0; j < 17; j++) begin
            in_valid = (j % 2 == 0);
            in_data = 32'h50000000 + 32'(j);
            tpu_done = (j == 13);
            #1;
            chk("s2_ready", 32'(in_ready), 1);
            if (in_valid && ai < 6) begin
                chk("s2_a_wr", 32'(wr_en_a), 1);
                chk("s2_a_idx", 32'(index_a), 32'(ai));
                chk("s2_a_dat", data_out_a, in_data);
                chk("s2_a_wrb", 32'(wr_en_b), 0);
                hold_a = 16'(ai);
                last_a = in_data;
                ai++;
            end else if (in_valid) begin
                chk("s2_b_wr", 32'(wr_en_b), 1);
                chk("s2_b_idx", 32'(index_b), 32'(bi));
                chk("s2_b_dat", data_out_b, in_data);
                chk("s2_b_wra", 32'(wr_en_a), 0);
                hold_b = 16'(bi);
                last_b = in_data;
                bi++;
            end else begin
                chk("s2_idle_wra", 32'(wr_en_a), 0);
                chk("s2_idle_wrb", 32'(wr_en_b), 0);
                chk("s2_idle_idxa", 32'(index_a), 32'(hold_a));
                chk("s2_idle_idxb", 32'(index_b), 32'(hold_b));
                chk("s2_idle_data", data_out_a, last_a);
                chk("s2_idle_datb", data_out_b, last_b);
            end
            cyc();
        end
        tpu_done = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("s2_start", 32'(tpu_start), 1);
        chk("s2_done_ignored", 32'(done), 0);
`ifdef GBUFF_LOADER_PERF_EN
        chk("s2_stall", 32'(stall_cnt), 8);
`endif
        cyc();

        // Scenario 6: cfg during WAIT ignored
        cfg_valid = 1'b1;
        m = 4'd1;
        k = 4'd1;
        n = 4'd1;
        #1;
        chk("s6_wait_busy", 32'(busy), 1);
        cyc();
        cfg_valid = 1'b0;
        #1;
        chk("s6_still_wait", 32'(busy), 1);
        chk("s6_no_ready", 32'(in_ready), 0);
        tpu_done = 1'b1;
        cyc();
        tpu_done = 1'b0;
        #1;
        chk("s6_done", 32'(done), 1);
        chk("s6_idle", 32'(busy), 0);
        in_valid = 1'b1;
        in_data = 32'h77777777;
        for (int i = 0; i < 2; i++) begin
            cyc();
            #1;
            chk("s6_idle_ready", 32'(in_ready), 0);
            chk("s6_idle_wra", 32'(wr_en_a), 0);
            chk("s6_idle_busy", 32'(busy), 0);
        end
        cfg_valid = 1'b1;
        cyc();
        cfg_valid = 1'b0;
        in_data = 32'hC0000000;
        #1;
        chk("s6_a_wr", 32'(wr_en_a), 1);
        chk("s6_a_idx", 32'(index_a), 0);
        cyc();
        in_data = 32'hC1000000;
        #1;
        chk("s6_b_wr", 32'(wr_en_b), 1);
        chk("s6_b_idx", 32'(index_b), 0);
        chk("s6_b_dat", data_out_b, 32'hC1000000);
        cyc();
        in_valid = 1'b0;
        #1;
        chk("s6_start", 32'(tpu_start), 1);
`ifdef GBUFF_LOADER_PERF_EN
        chk("s6_stall_clr", 32'(stall_cnt), 0);
`endif
        cyc();
        tpu_done = 1'b1;
        cyc();
        tpu_done = 1'b0;
        #1;
        chk("s6_done2", 32'(done), 1);

        // Scenario 3: illegal cfg, then legal cfg clears err
        cfg_valid = 1'b1;
        m = 4'd4;
        k = 4'd0;
        n = 4'd4;
        in_valid = 1'b1;
        cyc();
        cfg_valid = 1'b0;
        #1;
        chk("s3_err", 32'(err), 1);
        chk("s3_busy", 32'(busy), 0);
        chk("s3_ready", 32'(in_ready), 0);
        chk("s3_wra", 32'(wr_en_a), 0);
        cyc();
        #1;
        chk("s3_start", 32'(tpu_start), 0);
        chk("s3_err_sticky", 32'(err), 1);
        cfg_valid = 1'b1;
        k = 4'd2;
        n = 4'd8;
        cyc();
        cfg_valid = 1'b0;
        #1;
        chk("s3_err_clr", 32'(err), 0);
        chk("s3_busy2", 32'(busy), 1);

        // Scenario 4: NA=2 NB=4, reset after second B write
        for (int i = 0; i < 2; i++) begin
            in_data = 32'hE0000000 | 32'(i);
            #1;
            chk("s4_a_wr", 32'(wr_en_a), 1);
            chk("s4_a_idx", 32'(index_a), 32'(i));
            cyc();
        end
        for (int i = 0; i < 2; i++) begin
            in_data = 32'hF0000000 | 32'(i);
            #1;
            chk("s4_b_wr", 32'(wr_en_b), 1);
            chk("s4_b_idx", 32'(index_b), 32'(i));
            cyc();
        end
        rst = 1'b1;
        #1;
        chk_all_zero("s4_rst");
`ifdef GBUFF_LOADER_PERF_EN
        chk("s4_stall_rst", 32'(stall_cnt), 0);
`endif
        cyc();
        #1;
        chk("s4_rst_wrb", 32'(wr_en_b), 0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            #1;
            chk("s4_post_ready", 32'(in_ready), 0);
            chk("s4_post_wrb", 32'(wr_en_b), 0);
            chk("s4_post_busy", 32'(busy), 0);
            chk("s4_post_start", 32'(tpu_start), 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
